// File: rtl/core_pkg.sv
// Shared core types and defaults used by the writeback path.
package core_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned TAG_W  = 5;
  localparam int unsigned NUM_FU = 3;

  typedef struct packed {
    logic [DATA_W-1:0] value;
    logic [TAG_W-1:0]  rob_idx;
  } wb_entry_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Functional-unit writeback channels in, ROB update ports out.
interface wb_arbiter_if #(
  parameter int unsigned NUM_CH   = core_pkg::NUM_FU,
  parameter int unsigned WB_PORTS = 1,
  parameter int unsigned DATA_W   = core_pkg::DATA_W,
  parameter int unsigned TAG_W    = core_pkg::TAG_W
);

  logic [NUM_CH-1:0]          ch_valid_i;
  logic [NUM_CH-1:0]          ch_ready_o;
  logic [NUM_CH*DATA_W-1:0]   ch_value_i;
  logic [NUM_CH*TAG_W-1:0]    ch_rob_idx_i;
  logic                       wb_ready_i;
  logic [WB_PORTS-1:0]        wb_valid_o;
  logic [WB_PORTS*DATA_W-1:0] wb_value_o;
  logic [WB_PORTS*TAG_W-1:0]  wb_rob_idx_o;

  // Arbiter side.
  modport slave (
    input  ch_valid_i, ch_value_i, ch_rob_idx_i, wb_ready_i,
    output ch_ready_o, wb_valid_o, wb_value_o, wb_rob_idx_o
  );

  // Functional-unit / ROB side.
  modport master (
    output ch_valid_i, ch_value_i, ch_rob_idx_i, wb_ready_i,
    input  ch_ready_o, wb_valid_o, wb_value_o, wb_rob_idx_o
  );

endinterface

// File: rtl/wb_fifo.sv
// Single-channel writeback FIFO with synchronous clear; a full FIFO never accepts.
module wb_fifo #(
  parameter int unsigned Depth = 2,
  parameter type entry_t = logic [31:0]
) (
  input  logic   clk_i,
  input  logic   clr_i,
  input  logic   push_i,
  input  logic   pop_i,
  input  entry_t data_i,
  output entry_t data_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] FullCount = (PtrW + 1)'(Depth);

  entry_t          mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q, count_d;
  logic            do_push, do_pop;

  assign full_o  = (count_q == FullCount);
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q + {{PtrW{1'b0}}, do_push} - {{PtrW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter: per-channel FIFOs drained into registered ROB update ports.
module wb_arbiter #(
  parameter int unsigned NUM_CH     = core_pkg::NUM_FU,
  parameter int unsigned WB_PORTS   = 1,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned DATA_W     = core_pkg::DATA_W,
  parameter int unsigned TAG_W      = core_pkg::TAG_W
) (
  input logic          clk_i,
  input logic          reset_i,
  input logic          flush_i,
  wb_arbiter_if.slave  bus
);

  localparam int unsigned ChW = $clog2(NUM_CH);

  typedef struct packed {
    logic [DATA_W-1:0] value;
    logic [TAG_W-1:0]  rob_idx;
  } entry_t;

  logic                clr;
  logic                can_load;
  logic [NUM_CH-1:0]   full, empty, push, pop;
  entry_t              head [NUM_CH];
  logic [ChW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [WB_PORTS-1:0] wb_valid_q, wb_valid_d;
  entry_t              wb_entry_q [WB_PORTS];
  entry_t              wb_entry_d [WB_PORTS];
  logic [ChW:0]        scan_sum;
  logic [ChW-1:0]      scan_ch;
  int unsigned         n_grant;

  assign clr            = reset_i | flush_i;
  assign bus.ch_ready_o = ~full & {NUM_CH{~clr}};
  assign push           = bus.ch_valid_i & bus.ch_ready_o;
  // Output stage loads when the ROB takes it or nothing is currently presented.
  assign can_load       = bus.wb_ready_i | ~(|wb_valid_q);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    entry_t din;
    assign din.value   = bus.ch_value_i[c*DATA_W +: DATA_W];
    assign din.rob_idx = bus.ch_rob_idx_i[c*TAG_W +: TAG_W];

    wb_fifo #(
      .Depth   (FIFO_DEPTH),
      .entry_t (entry_t)
    ) u_fifo (
      .clk_i   (clk_i),
      .clr_i   (clr),
      .push_i  (push[c]),
      .pop_i   (pop[c]),
      .data_i  (din),
      .data_o  (head[c]),
      .full_o  (full[c]),
      .empty_o (empty[c])
    );
  end

  always_comb begin
    pop        = '0;
    wb_valid_d = wb_valid_q;
    wb_entry_d = wb_entry_q;
    rr_ptr_d   = rr_ptr_q;
    scan_sum   = '0;
    scan_ch    = '0;
    n_grant    = 0;
    if (can_load) begin
      wb_valid_d = '0;
      for (int unsigned p = 0; p < WB_PORTS; p++) begin
        wb_entry_d[p] = '0;
      end
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        scan_sum = {1'b0, rr_ptr_q} + (ChW + 1)'(i);
        if (scan_sum >= (ChW + 1)'(NUM_CH)) begin
          scan_sum = scan_sum - (ChW + 1)'(NUM_CH);
        end
        scan_ch = scan_sum[ChW-1:0];
        if (!empty[scan_ch] && (n_grant < WB_PORTS)) begin
          // The k-th grant of the cycle lands on port k.
          for (int unsigned p = 0; p < WB_PORTS; p++) begin
            if (n_grant == p) begin
              wb_valid_d[p] = 1'b1;
              wb_entry_d[p] = head[scan_ch];
            end
          end
          pop[scan_ch] = 1'b1;
          n_grant      = n_grant + 1;
          rr_ptr_d     = (scan_ch == ChW'(NUM_CH - 1)) ? '0 : scan_ch + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr) begin
      rr_ptr_q   <= '0;
      wb_valid_q <= '0;
      for (int unsigned p = 0; p < WB_PORTS; p++) begin
        wb_entry_q[p] <= '0;
      end
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      wb_valid_q <= wb_valid_d;
      wb_entry_q <= wb_entry_d;
    end
  end

  assign bus.wb_valid_o = wb_valid_q;
  for (genvar p = 0; p < WB_PORTS; p++) begin : g_out
    assign bus.wb_value_o[p*DATA_W +: DATA_W] = wb_entry_q[p].value;
    assign bus.wb_rob_idx_o[p*TAG_W +: TAG_W] = wb_entry_q[p].rob_idx;
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench: vector table, round-robin scoreboard and hand-written corner sequences.
module tb_wb_arbiter;

  localparam int unsigned NCh = 3;
  localparam int unsigned DW  = 32;
  localparam int unsigned TW  = 5;

  logic clk = 1'b0;
  logic reset;
  logic flush_a;
  logic flush_b;

  always #5 clk = ~clk;

  wb_arbiter_if #(.NUM_CH(NCh), .WB_PORTS(1), .DATA_W(DW), .TAG_W(TW)) bus_a ();
  wb_arbiter_if #(.NUM_CH(NCh), .WB_PORTS(2), .DATA_W(DW), .TAG_W(TW)) bus_b ();

  wb_arbiter #(
    .NUM_CH(NCh), .WB_PORTS(1), .FIFO_DEPTH(2), .DATA_W(DW), .TAG_W(TW)
  ) u_dut1 (
    .clk_i   (clk),
    .reset_i (reset),
    .flush_i (flush_a),
    .bus     (bus_a)
  );

  wb_arbiter #(
    .NUM_CH(NCh), .WB_PORTS(2), .FIFO_DEPTH(2), .DATA_W(DW), .TAG_W(TW)
  ) u_dut2 (
    .clk_i   (clk),
    .reset_i (reset),
    .flush_i (flush_b),
    .bus     (bus_b)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       v0;
    logic [4:0] idx;
    logic       rdy;
    logic       fl;
    logic [2:0] exp_ready;
    logic       exp_v;
    logic [4:0] exp_idx;
  } vec_t;

  vec_t vec [13];

  logic [36:0] sb0[$];
  logic [36:0] sb1[$];
  logic [36:0] sb2[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] val_of(input logic [4:0] idx);
    return 32'hC0DE_0000 | {27'b0, idx};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input int c, input logic [4:0] idx);
    bus_a.ch_value_i[c*DW +: DW]   = val_of(idx);
    bus_a.ch_rob_idx_i[c*TW +: TW] = idx;
  endtask

  task automatic set_b(input int c, input logic [4:0] idx);
    bus_b.ch_value_i[c*DW +: DW]   = val_of(idx);
    bus_b.ch_rob_idx_i[c*TW +: TW] = idx;
  endtask

  task automatic sb_pop(input int ch, output logic [36:0] e, output bit ok);
    ok = 1'b1;
    e  = '0;
    case (ch)
      0: if (sb0.size() > 0) e = sb0.pop_front(); else ok = 1'b0;
      1: if (sb1.size() > 0) e = sb1.pop_front(); else ok = 1'b0;
      2: if (sb2.size() > 0) e = sb2.pop_front(); else ok = 1'b0;
      default: ok = 1'b0;
    endcase
  endtask

  task automatic flush_dut1();
    flush_a = 1'b1;
    tick();
    flush_a = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          n [3];
    int          got;
    logic [2:0]  acc;
    logic [4:0]  oidx;
    logic [36:0] ent;
    bit          ok;

    // ch0 only: backpressure fill/drain, then flush with two queued and one presented.
    vec[0]  = '{1'b1, 5'h10, 1'b0, 1'b0, 3'b111, 1'b0, 5'h00};
    vec[1]  = '{1'b1, 5'h11, 1'b0, 1'b0, 3'b111, 1'b1, 5'h10};
    vec[2]  = '{1'b1, 5'h12, 1'b0, 1'b0, 3'b111, 1'b1, 5'h10};
    vec[3]  = '{1'b1, 5'h13, 1'b0, 1'b0, 3'b110, 1'b1, 5'h10};
    vec[4]  = '{1'b0, 5'h13, 1'b1, 1'b0, 3'b110, 1'b1, 5'h11};
    vec[5]  = '{1'b0, 5'h13, 1'b1, 1'b0, 3'b111, 1'b1, 5'h12};
    vec[6]  = '{1'b0, 5'h13, 1'b1, 1'b0, 3'b111, 1'b0, 5'h00};
    vec[7]  = '{1'b1, 5'h13, 1'b0, 1'b0, 3'b111, 1'b0, 5'h00};
    vec[8]  = '{1'b1, 5'h14, 1'b0, 1'b0, 3'b111, 1'b1, 5'h13};
    vec[9]  = '{1'b1, 5'h15, 1'b0, 1'b0, 3'b111, 1'b1, 5'h13};
    vec[10] = '{1'b1, 5'h16, 1'b1, 1'b1, 3'b000, 1'b0, 5'h00};
    vec[11] = '{1'b0, 5'h16, 1'b1, 1'b0, 3'b111, 1'b0, 5'h00};
    vec[12] = '{1'b0, 5'h16, 1'b1, 1'b0, 3'b111, 1'b0, 5'h00};

    reset = 1'b1;
    flush_a = 1'b0;
    flush_b = 1'b0;
    bus_a.ch_valid_i = '0;
    bus_a.ch_value_i = '0;
    bus_a.ch_rob_idx_i = '0;
    bus_a.wb_ready_i = 1'b1;
    bus_b.ch_valid_i = '0;
    bus_b.ch_value_i = '0;
    bus_b.ch_rob_idx_i = '0;
    bus_b.wb_ready_i = 1'b1;
    tick();
    tick();

    check("rst_valid", bus_a.wb_valid_o, 0);
    check("rst_value", bus_a.wb_value_o, 0);
    check("rst_idx", bus_a.wb_rob_idx_o, 0);
    check("rst_ready", bus_a.ch_ready_o, 0);
    reset = 1'b0;
    #1;
    check("post_rst_ready", bus_a.ch_ready_o, 3'b111);

    // Single result through ch1.
    bus_a.ch_value_i[1*DW +: DW]   = 32'hDEADBEEF;
    bus_a.ch_rob_idx_i[1*TW +: TW] = 5'd7;
    bus_a.ch_valid_i = 3'b010;
    tick();
    bus_a.ch_valid_i = '0;
    check("single_not_yet", bus_a.wb_valid_o, 0);
    tick();
    check("single_valid", bus_a.wb_valid_o, 1);
    check("single_value", bus_a.wb_value_o, 32'hDEADBEEF);
    check("single_idx", bus_a.wb_rob_idx_o, 7);
    tick();
    check("single_gone", bus_a.wb_valid_o, 0);
    flush_dut1();

    // Round robin with all channels pushing every cycle.
    n[0] = 0;
    n[1] = 0;
    n[2] = 0;
    got = 0;
    for (int cyc = 0; cyc < 60 && got < 12; cyc++) begin
      for (int c = 0; c < 3; c++) begin
        set_a(c, 5'(c * 8 + n[c]));
        bus_a.ch_valid_i[c] = (n[c] < 7);
      end
      #1;
      acc = bus_a.ch_valid_i & bus_a.ch_ready_o;
      tick();
      for (int c = 0; c < 3; c++) begin
        if (acc[c]) begin
          case (c)
            0: sb0.push_back({5'(c * 8 + n[c]), val_of(5'(c * 8 + n[c]))});
            1: sb1.push_back({5'(c * 8 + n[c]), val_of(5'(c * 8 + n[c]))});
            default: sb2.push_back({5'(c * 8 + n[c]), val_of(5'(c * 8 + n[c]))});
          endcase
          n[c]++;
        end
      end
      if (bus_a.wb_valid_o[0]) begin
        oidx = bus_a.wb_rob_idx_o;
        check($sformatf("rr_order%0d", got), oidx, (got % 3) * 8 + got / 3);
        sb_pop(int'(oidx[4:3]), ent, ok);
        check($sformatf("rr_sb_hit%0d", got), ok, 1);
        check($sformatf("rr_sb_idx%0d", got), oidx, ent[36:32]);
        check($sformatf("rr_sb_val%0d", got), bus_a.wb_value_o, ent[31:0]);
        got++;
      end
    end
    check("rr_count", got, 12);
    bus_a.ch_valid_i = '0;
    flush_dut1();
    sb0.delete();
    sb1.delete();
    sb2.delete();

    // Vector table on ch0.
    for (int i = 0; i < 13; i++) begin
      bus_a.ch_valid_i = {2'b00, vec[i].v0};
      set_a(0, vec[i].idx);
      bus_a.wb_ready_i = vec[i].rdy;
      flush_a = vec[i].fl;
      #1;
      check($sformatf("tbl%0d_ready", i), bus_a.ch_ready_o, vec[i].exp_ready);
      tick();
      check($sformatf("tbl%0d_valid", i), bus_a.wb_valid_o, vec[i].exp_v);
      if (vec[i].exp_v) begin
        check($sformatf("tbl%0d_idx", i), bus_a.wb_rob_idx_o, vec[i].exp_idx);
        check($sformatf("tbl%0d_value", i), bus_a.wb_value_o, val_of(vec[i].exp_idx));
      end
    end
    bus_a.ch_valid_i = '0;
    bus_a.wb_ready_i = 1'b1;
    flush_a = 1'b0;

    // Flush restarts the round-robin pointer at ch0.
    set_a(1, 5'h01);
    set_a(2, 5'h02);
    bus_a.ch_valid_i = 3'b110;
    tick();
    bus_a.ch_valid_i = '0;
    tick();
    check("rrf_first", bus_a.wb_rob_idx_o, 5'h01);
    flush_dut1();
    check("rrf_flushed", bus_a.wb_valid_o, 0);
    set_a(0, 5'h03);
    set_a(2, 5'h04);
    bus_a.ch_valid_i = 3'b101;
    tick();
    bus_a.ch_valid_i = '0;
    tick();
    check("rrf_ch0_first", bus_a.wb_rob_idx_o, 5'h03);
    tick();
    check("rrf_ch2_next", bus_a.wb_rob_idx_o, 5'h04);

    // Dual-port instance.
    set_b(0, 5'h0A);
    set_b(2, 5'h0C);
    bus_b.ch_valid_i = 3'b101;
    tick();
    bus_b.ch_valid_i = '0;
    tick();
    check("dual_valid", bus_b.wb_valid_o, 2'b11);
    check("dual_p0_idx", bus_b.wb_rob_idx_o[0 +: TW], 5'h0A);
    check("dual_p1_idx", bus_b.wb_rob_idx_o[TW +: TW], 5'h0C);
    check("dual_p1_val", bus_b.wb_value_o[DW +: DW], val_of(5'h0C));
    set_b(0, 5'h01);
    set_b(1, 5'h02);
    set_b(2, 5'h03);
    bus_b.ch_valid_i = 3'b111;
    tick();
    bus_b.ch_valid_i = '0;
    tick();
    check("dual3_valid", bus_b.wb_valid_o, 2'b11);
    check("dual3_p0", bus_b.wb_rob_idx_o[0 +: TW], 5'h01);
    check("dual3_p1", bus_b.wb_rob_idx_o[TW +: TW], 5'h02);
    tick();
    check("dual3_tail_valid", bus_b.wb_valid_o, 2'b01);
    check("dual3_tail_idx", bus_b.wb_rob_idx_o[0 +: TW], 5'h03);

    // Reset with every FIFO full and an output held.
    bus_a.wb_ready_i = 1'b0;
    set_a(0, 5'h18);
    set_a(1, 5'h19);
    set_a(2, 5'h1A);
    bus_a.ch_valid_i = 3'b111;
    for (int i = 0; i < 4; i++) tick();
    check("mid_full_ready", bus_a.ch_ready_o, 3'b000);
    check("mid_held_valid", bus_a.wb_valid_o, 1);
    reset = 1'b1;
    tick();
    check("mid_rst_valid", bus_a.wb_valid_o, 0);
    check("mid_rst_value", bus_a.wb_value_o, 0);
    check("mid_rst_idx", bus_a.wb_rob_idx_o, 0);
    check("mid_rst_ready", bus_a.ch_ready_o, 0);
    reset = 1'b0;
    bus_a.ch_valid_i = '0;
    bus_a.wb_ready_i = 1'b1;
    #1;
    check("mid_post_ready", bus_a.ch_ready_o, 3'b111);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("mid_no_stale%0d", i), bus_a.wb_valid_o, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
